// File: rtl/rcc_dom_rst_seq.sv
// Per-domain reset/clock-enable sequencer. Each domain runs ASSERT -> WAIT_CLK -> RUN;
// with CHAIN=1 a domain is held in ASSERT until its predecessor is in RUN.

module rcc_dom_lane #(
  parameter int RST_DUR = 10,
  parameter int CLK_DLY = 8,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic held,
  output logic rst_out,
  output logic clk_en,
  output logic rdy
);
  typedef enum logic [1:0] {ASSERT, WAIT_CLK, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_DUR);
  localparam logic [CNT_W-1:0] CLK_END = CNT_W'(CLK_DLY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // Outputs are registered alongside the state so they carry no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ASSERT;
      cnt     <= '0;
      rst_out <= 1'b0;
      clk_en  <= 1'b0;
      rdy     <= 1'b0;
    end else if (req || held) begin
      state   <= ASSERT;
      cnt     <= '0;
      rst_out <= 1'b0;
      clk_en  <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      case (state)
        ASSERT: begin
          if (cnt_inc == RST_END) begin
            cnt     <= '0;
            rst_out <= 1'b1;
            if (CLK_DLY == 0) begin
              state  <= RUN;
              clk_en <= 1'b1;
              rdy    <= 1'b1;
            end else begin
              state  <= WAIT_CLK;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_CLK: begin
          if (cnt_inc == CLK_END) begin
            state  <= RUN;
            cnt    <= '0;
            clk_en <= 1'b1;
            rdy    <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end
endmodule

module rcc_dom_rst_seq #(
  parameter int N_DOM   = 4,
  parameter int RST_DUR = 10,
  parameter int CLK_DLY = 8,
  parameter int CNT_W   = 8,
  parameter int CHAIN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_DOM-1:0] rst_req,
  input  logic             flag_clr,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic [N_DOM-1:0] dom_clk_en,
  output logic [N_DOM-1:0] dom_rdy,
  output logic             busy,
  output logic [N_DOM-1:0] rst_flag
);
  logic [N_DOM-1:0] held;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    // Parent readiness comes from its registered rdy, so a parent reset reaches
    // the child one edge later, one level per cycle.
    if (CHAIN != 0 && i > 0) begin : g_held
      assign held[i] = ~dom_rdy[i-1];
    end else begin : g_free
      assign held[i] = 1'b0;
    end

    rcc_dom_lane #(
      .RST_DUR(RST_DUR),
      .CLK_DLY(CLK_DLY),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (rst_req[i]),
      .held   (held[i]),
      .rst_out(dom_rst_n[i]),
      .clk_en (dom_clk_en[i]),
      .rdy    (dom_rdy[i])
    );
  end

  assign busy = ~&dom_rdy;

  // A request on the same edge as a clear wins, so no request is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_flag <= '0;
    else        rst_flag <= (flag_clr ? '0 : rst_flag) | rst_req;
  end
endmodule

// File: tb/tb_rcc_dom_rst_seq.sv
// Bench for rcc_dom_rst_seq: chained and independent instances against an age-based model.
module tb_rcc_dom_rst_seq;
  localparam int N  = 4;
  localparam int RD = 10;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] rst_req = '0;
  logic flag_clr = 1'b0;

  logic [N-1:0] rst_c, clk_c, rdy_c, flag_c, rst_f, clk_f, rdy_f, flag_f;
  logic busy_c, busy_f;

  always #5 clk = ~clk;

  rcc_dom_rst_seq #(.N_DOM(N), .RST_DUR(RD), .CLK_DLY(CD), .CNT_W(8), .CHAIN(1)) u_chain (
    .clk(clk), .rst_n(rst_n), .rst_req(rst_req), .flag_clr(flag_clr),
    .dom_rst_n(rst_c), .dom_clk_en(clk_c), .dom_rdy(rdy_c), .busy(busy_c), .rst_flag(flag_c));

  rcc_dom_rst_seq #(.N_DOM(N), .RST_DUR(RD), .CLK_DLY(CD), .CNT_W(8), .CHAIN(0)) u_flat (
    .clk(clk), .rst_n(rst_n), .rst_req(rst_req), .flag_clr(flag_clr),
    .dom_rst_n(rst_f), .dom_clk_en(clk_f), .dom_rdy(rdy_f), .busy(busy_f), .rst_flag(flag_f));

  // Model: each domain's "age" = edges since it was last requested/held, saturating.
  // Reset released once age >= RD, clock enabled once age >= RD+CD.
  int age_c [N];
  int age_f [N];
  logic [N-1:0] mflag;
  int ecount;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        age_c[i] <= 0;
        age_f[i] <= 0;
      end
      mflag  <= '0;
      ecount <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rst_req[i] || (i > 0 && age_c[i-1] < RD + CD)) age_c[i] <= 0;
        else if (age_c[i] < RD + CD)                        age_c[i] <= age_c[i] + 1;
        if (rst_req[i])              age_f[i] <= 0;
        else if (age_f[i] < RD + CD) age_f[i] <= age_f[i] + 1;
      end
      mflag  <= (flag_clr ? '0 : mflag) | rst_req;
      ecount <= ecount + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  // Edge numbers (relative to rst_n release) of the most recent output transitions.
  int fall_r [N];
  int rise_r [N];
  int cken_r [N];
  int rise_f [N];
  int cken_f [N];
  int bfall;
  logic [N-1:0] p_rst_c, p_clk_c, p_rst_f, p_clk_f;
  logic p_busy;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
  endtask

  task automatic tick();
    logic [N-1:0] er_c, ec_c, er_f, ec_f;
    logic [4*N:0] exp_v, act_v;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      er_c[i] = age_c[i] >= RD;
      ec_c[i] = age_c[i] >= RD + CD;
      er_f[i] = age_f[i] >= RD;
      ec_f[i] = age_f[i] >= RD + CD;
    end
    exp_v = {er_c, ec_c, ec_c, ~&ec_c, mflag};
    act_v = {rst_c, clk_c, rdy_c, busy_c, flag_c};
    n_chk++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL cyc_chain: got %h expected %h (edge %0d)", act_v, exp_v, ecount);
    exp_v = {er_f, ec_f, ec_f, ~&ec_f, mflag};
    act_v = {rst_f, clk_f, rdy_f, busy_f, flag_f};
    n_chk++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL cyc_flat: got %h expected %h (edge %0d)", act_v, exp_v, ecount);

    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        fall_r[i] = -1; rise_r[i] = -1; cken_r[i] = -1; rise_f[i] = -1; cken_f[i] = -1;
      end
      bfall = -1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!rst_c[i] && p_rst_c[i]) fall_r[i] = ecount;
        if (rst_c[i] && !p_rst_c[i]) rise_r[i] = ecount;
        if (clk_c[i] && !p_clk_c[i]) cken_r[i] = ecount;
        if (rst_f[i] && !p_rst_f[i]) rise_f[i] = ecount;
        if (clk_f[i] && !p_clk_f[i]) cken_f[i] = ecount;
      end
      if (!busy_c && p_busy) bfall = ecount;
    end
    p_rst_c = rst_c; p_clk_c = clk_c; p_rst_f = rst_f; p_clk_f = clk_f; p_busy = busy_c;
  endtask

  task automatic por_check();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("por_rst_rise[%0d]", i), rise_r[i], 10 + 18 * i);
      chk($sformatf("por_clk_rise[%0d]", i), cken_r[i], 18 + 18 * i);
      chk($sformatf("flat_rst_rise[%0d]", i), rise_f[i], 10);
      chk($sformatf("flat_clk_rise[%0d]", i), cken_f[i], 18);
    end
    chk("por_busy_fall", bfall, 72);
    chk("por_flags", int'(flag_c), 0);
  endtask

  task automatic async_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_c", int'(rst_c | clk_c | rdy_c | flag_c), 0);
    chk("async_rst_f", int'(rst_f | clk_f | rdy_f | flag_f), 0);
    chk("async_busy", int'({busy_c, busy_f}), 3);
    tick();
    rst_n = 1'b1;
  endtask

  int k, k2;

  initial begin
    repeat (3) tick();
    chk("reset_rst_n", int'(rst_c), 0);
    chk("reset_busy", int'(busy_c), 1);
    rst_n = 1'b1;
    repeat (80) tick();
    por_check();

    // Single-cycle request on domain 1 with everything running.
    rst_req = 4'b0010; k = ecount + 1;
    tick();
    rst_req = '0;
    repeat (60) tick();
    chk("r1_fall1", fall_r[1], k);
    chk("r1_rise1", rise_r[1], k + 10);
    chk("r1_clk1", cken_r[1], k + 18);
    chk("r1_fall2", fall_r[2], k + 1);
    chk("r1_rise2", rise_r[2], k + 28);
    chk("r1_clk2", cken_r[2], k + 36);
    chk("r1_fall3", fall_r[3], k + 2);
    chk("r1_dom0_fall", fall_r[0], -1);
    chk("r1_flag", int'(flag_c), 4'b0010);

    // Five-cycle request on domain 0: counter restarts every requested edge.
    rst_req = 4'b0001; k = ecount + 1;
    repeat (5) tick();
    rst_req = '0;
    repeat (85) tick();
    chk("r0_hold_rise", rise_r[0], k + 14);

    // Domain 2 re-requested while in WAIT_CLK, together with flag_clr.
    rst_req = 4'b0100;
    tick();
    rst_req = '0;
    repeat (12) tick();
    chk("r2_in_wait", int'({rst_c[2], clk_c[2]}), 2'b10);
    rst_req = 4'b0100; flag_clr = 1'b1; k2 = ecount + 1;
    tick();
    rst_req = '0; flag_clr = 1'b0;
    chk("r2_flags", int'(flag_c), 4'b0100);
    chk("r2_flags_flat", int'(flag_f), 4'b0100);
    repeat (70) tick();
    chk("r2_fall", fall_r[2], k2);
    chk("r2_rise", rise_r[2], k2 + 10);
    chk("r2_clk", cken_r[2], k2 + 18);

    // rst_n pulse while domain 1 is in WAIT_CLK restarts the POR sequence.
    async_pulse();
    repeat (30) tick();
    chk("por2_dom1_wait", int'({rst_c[1], clk_c[1]}), 2'b10);
    async_pulse();
    repeat (80) tick();
    por_check();

    // Random requests and flag clears, checked every cycle against the model.
    repeat (600) begin
      for (int i = 0; i < N; i++) rst_req[i] = ($urandom_range(0, 15) == 0);
      flag_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_req = '0; flag_clr = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rcc_dom_rst_seq.md
RCC_DOM_RST_SEQ -- requirements
Module: rcc_dom_rst_seq

Interface
REQ-001 The block SHALL have parameter N_DOM, default 4, number of reset/clock domains (1..16).
REQ-002 The block SHALL have parameter RST_DUR, default 10, cycles a domain reset is held asserted (>=1).
REQ-003 The block SHALL have parameter CLK_DLY, default 8, cycles from domain reset release to clock enable (>=0).
REQ-004 The block SHALL have parameter CNT_W, default 8, counter width; it SHALL hold max(RST_DUR, CLK_DLY).
REQ-005 The block SHALL have parameter CHAIN, default 1; 1 = domain i depends on domain i-1, 0 = all domains independent.
REQ-006 The block SHALL have port clk, input, 1, sole clock.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port rst_req, input, N_DOM, per-domain reset request, sampled each clk edge.
REQ-009 The block SHALL have port flag_clr, input, 1, clears all rst_flag bits.
REQ-010 The block SHALL have port dom_rst_n, output, N_DOM, per-domain active-low reset, registered.
REQ-011 The block SHALL have port dom_clk_en, output, N_DOM, per-domain clock-gate enable, registered.
REQ-012 The block SHALL have port dom_rdy, output, N_DOM, 1 while the domain is in RUN.
REQ-013 The block SHALL have port busy, output, 1, OR of ~dom_rdy.
REQ-014 The block SHALL have port rst_flag, output, N_DOM, sticky "reset by request" flags.

Function
REQ-015 Each domain SHALL run its own FSM with states ASSERT (rst_n=0, clk_en=0), WAIT_CLK (rst_n=1, clk_en=0) and RUN (rst_n=1, clk_en=1).
REQ-016 Domain i is "held" when CHAIN=1, i>0 and domain i-1 is not in RUN; domain 0, and every domain when CHAIN=0, is never held.
REQ-017 In ASSERT, the counter SHALL clear while the domain is held or rst_req[i]=1, and otherwise increment.
REQ-018 ASSERT->WAIT_CLK SHALL occur on the edge where the counter would reach RST_DUR; the counter clears on entry to WAIT_CLK.
REQ-019 WAIT_CLK->RUN SHALL occur after exactly CLK_DLY edges; if CLK_DLY=0, ASSERT SHALL go directly to RUN.
REQ-020 From WAIT_CLK or RUN, rst_req[i]=1 or held SHALL force ASSERT on that edge with the counter cleared.
REQ-021 Simultaneous rst_req and held SHALL behave identically to either alone; there is no priority difference.
REQ-022 Parent reset SHALL propagate down the chain one cycle per level: child enters ASSERT one edge after the parent leaves RUN.
REQ-023 rst_flag[i] SHALL set on any edge with rst_req[i]=1; flag_clr SHALL clear all bits; simultaneous set and clr SHALL set.
REQ-024 All outputs SHALL be registered or derived only from state registers, with no combinational path from inputs.

Reset
REQ-025 While rst_n=0, all domains SHALL be in ASSERT with counters 0, and dom_rst_n, dom_clk_en, dom_rdy, rst_flag = 0, busy = 1.
REQ-026 rst_n assertion mid-sequence SHALL immediately and asynchronously return all outputs to their reset values, abandoning counts.
REQ-027 After rst_n release, the power-on sequence SHALL be the normal ASSERT flow; rst_flag SHALL stay 0 unless requested.

Verification
REQ-028 POR (N_DOM=4, CHAIN=1, defaults): counting edges from rst_n release, dom_rst_n[i] rises at edge 10+18i and dom_clk_en[i] at 18+18i; busy falls at edge 72.
REQ-029 CHAIN=0 POR: all dom_rst_n rise at edge 10 and all dom_clk_en at edge 18.
REQ-030 Single-cycle rst_req[1] at edge k with all domains in RUN produces:
- dom_rst_n[1] falls at edge k and rises at k+10, with clk_en[1] rising at k+18;
- domain 2 falls at k+1, with rst rising at k+28 and clk rising at k+36;
- domain 3 falls at k+2;
- domain 0 is untouched;
- rst_flag[1]=1.
REQ-031 rst_req[0] held for 5 cycles from edge k: dom_rst_n[0] rises at k+14, because the counter restarts each requested cycle.
REQ-032 rst_req[2] in WAIT_CLK: domain 2 returns to ASSERT that edge and re-runs the full 10+8 sequence; flag_clr together with rst_req[2] leaves rst_flag[2]=1 and other flags 0.
REQ-033 rst_n pulsed low during domain-1 WAIT_CLK: all outputs go to 0 asynchronously and the REQ-028 timing restarts from the new release.
